// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS pipeline control blocks
package mips_pkg;
  // scoreboard dst field holds up to 256 registers; narrower indices are zero-extended
  localparam int SB_DST_W = 8;
  localparam logic [SB_DST_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {FWD_RF, FWD_M, FWD_W, FWD_RETIRE} t_fwd_sel;
  typedef struct packed {
    logic valid;
    logic [SB_DST_W-1:0] dst;
    logic regwrite;
    logic memread;
  } t_sb_slot;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: youngest-producer priority encoder for one D-stage source operand
module hazard_match import mips_pkg::*; #(
  parameter int NUM_STAGES = 3,
  parameter int SEL_W = $clog2(NUM_STAGES + 1)
) (
  input  logic [SB_DST_W-1:0]   src,
  input  logic                  uses,
  input  t_sb_slot [NUM_STAGES-1:0] slots,
  output logic                  hit,
  output logic                  load,
  output logic [SEL_W-1:0]      code
);
  // scan oldest to youngest so the lowest matching slot overrides; code is slot index + 1
  always_comb begin
    hit = 1'b0;
    load = 1'b0;
    code = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--)
      if (uses && src != REG_ZERO && slots[k].valid && slots[k].regwrite && slots[k].dst == src) begin
        hit = 1'b1;
        load = slots[k].memread;
        code = SEL_W'(k + 1);
      end
  end
endmodule

// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: destination scoreboard, RAW stall/flush control and X-stage forwarding selects
module mips_hazard_ctrl import mips_pkg::*; #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_STAGES = 3,
  parameter int FWD_EN = 1,
  parameter int LOAD_READY_STAGE = 2,
  parameter int CNT_W = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid_i,
  input  logic [REG_ADDR_W-1:0]             id_rs_i,
  input  logic [REG_ADDR_W-1:0]             id_rt_i,
  input  logic                              id_uses_rs_i,
  input  logic                              id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0]             id_dst_i,
  input  logic                              id_regwrite_i,
  input  logic                              id_memread_i,
  input  logic                              redirect_i,
  output logic                              stall_o,
  output logic                              bubble_o,
  output logic                              flush_o,
  output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_sel_a_o,
  output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_sel_b_o,
  output logic [NUM_STAGES-1:0]             slot_valid_o,
  output logic [CNT_W-1:0]                  stall_cnt_o,
  output logic [CNT_W-1:0]                  flush_cnt_o
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);
  t_sb_slot [NUM_STAGES-1:0] slot;
  logic hit_a, hit_b, load_a, load_b, haz_a, haz_b;
  logic [SEL_W-1:0] code_a, code_b;
  hazard_match #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_match_a (
    .src(SB_DST_W'(id_rs_i)),
    .uses(id_valid_i & id_uses_rs_i),
    .slots(slot),
    .hit(hit_a),
    .load(load_a),
    .code(code_a)
  );
  hazard_match #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_match_b (
    .src(SB_DST_W'(id_rt_i)),
    .uses(id_valid_i & id_uses_rt_i),
    .slots(slot),
    .hit(hit_b),
    .load(load_b),
    .code(code_b)
  );
  // a match stalls only while load data is not yet forwardable, or always when forwarding is off
  always_comb begin
    haz_a = (FWD_EN != 0) ? (hit_a & load_a & (int'(code_a) < LOAD_READY_STAGE)) : hit_a;
    haz_b = (FWD_EN != 0) ? (hit_b & load_b & (int'(code_b) < LOAD_READY_STAGE)) : hit_b;
  end
  // redirect discards the D instruction, so it overrides any stall
  assign stall_o = !redirect_i & (haz_a | haz_b);
  assign bubble_o = stall_o | redirect_i;
  assign flush_o = redirect_i;
  // expose per-slot valid bits
  always_comb begin
    slot_valid_o = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      slot_valid_o[k] = slot[k].valid;
  end
  // scoreboard shifts every cycle; a held or discarded D enters as an invalid slot
  always_ff @(posedge clk or posedge rst)
    if (rst)
      slot <= '0;
    else begin
      slot[0] <= (id_valid_i && !stall_o && !redirect_i)
                 ? '{valid: 1'b1, dst: SB_DST_W'(id_dst_i), regwrite: id_regwrite_i, memread: id_memread_i}
                 : '0;
      for (int k = 1; k < NUM_STAGES; k++)
        slot[k] <= slot[k-1];
    end
  // forwarding selects follow the D instruction into X; a bubble reads the register file
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fwd_sel_a_o <= SEL_W'(FWD_RF);
      fwd_sel_b_o <= SEL_W'(FWD_RF);
    end else begin
      fwd_sel_a_o <= (bubble_o || FWD_EN == 0) ? SEL_W'(FWD_RF) : code_a;
      fwd_sel_b_o <= (bubble_o || FWD_EN == 0) ? SEL_W'(FWD_RF) : code_b;
    end
  // saturating stall and flush cycle counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_o && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// tb_mips_hazard_ctrl: directed checks of stall, flush and forwarding with and without forwarding
module tb_mips_hazard_ctrl;
  logic clk, rst, id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, redirect;
  logic [4:0] id_rs, id_rt, id_dst;
  logic stall_f, bubble_f, flush_f, stall_n, bubble_n, flush_n;
  logic [1:0] fa_f, fb_f, fa_n, fb_n;
  logic [2:0] sv_f, sv_n;
  logic [31:0] sc_f, fc_f, sc_n, fc_n;
  int total = 0;
  int bad = 0;
  mips_hazard_ctrl u_f (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .id_dst_i(id_dst),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .redirect_i(redirect),
    .stall_o(stall_f), .bubble_o(bubble_f), .flush_o(flush_f), .fwd_sel_a_o(fa_f),
    .fwd_sel_b_o(fb_f), .slot_valid_o(sv_f), .stall_cnt_o(sc_f), .flush_cnt_o(fc_f)
  );
  mips_hazard_ctrl #(.FWD_EN(0)) u_n (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .id_dst_i(id_dst),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .redirect_i(redirect),
    .stall_o(stall_n), .bubble_o(bubble_n), .flush_o(flush_n), .fwd_sel_a_o(fa_n),
    .fwd_sel_b_o(fb_n), .slot_valid_o(sv_n), .stall_cnt_o(sc_n), .flush_cnt_o(fc_n)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic put(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic [4:0] dst, input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dst = dst; id_regwrite = rw; id_memread = mr;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    put(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    idle();
    #12;
    chk("rst_stall", stall_f, 0);
    chk("rst_bubble", bubble_f, 0);
    chk("rst_flush", flush_f, 0);
    chk("rst_fwd_a", fa_f, 0);
    chk("rst_fwd_b", fb_f, 0);
    chk("rst_slots", sv_f, 0);
    chk("rst_stall_cnt", sc_f, 0);
    chk("rst_flush_cnt", fc_f, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    // add r3,r1,r2 ; sub r4,r3,r1
    put(1, 1, 2, 1, 1, 3, 1, 0); #2;
    chk("t1_add_stall", stall_f, 0);
    tick();
    put(1, 3, 1, 1, 1, 4, 1, 0); #2;
    chk("t1_sub_stall", stall_f, 0);
    tick();
    idle(); #2;
    chk("t1_fwd_a", fa_f, 1);
    chk("t1_fwd_b", fb_f, 0);
    tick();
    // lw r5,0(r0) ; add r6,r5,r5
    put(1, 0, 0, 1, 0, 5, 1, 1); #2;
    chk("t2_lw_stall", stall_f, 0);
    tick();
    put(1, 5, 5, 1, 1, 6, 1, 0); #2;
    chk("t2_stall", stall_f, 1);
    chk("t2_bubble", bubble_f, 1);
    chk("t2_flush", flush_f, 0);
    tick();
    #2;
    chk("t2_stall_gone", stall_f, 0);
    chk("t2_bubble_fwd", fa_f, 0);
    tick();
    idle(); #2;
    chk("t2_fwd_a", fa_f, 2);
    chk("t2_fwd_b", fb_f, 2);
    chk("t2_stall_cnt", sc_f, 1);
    tick();
    // addi r0,r0,7 ; add r1,r0,r0
    put(1, 0, 0, 1, 0, 0, 1, 0); #2;
    tick();
    put(1, 0, 0, 1, 1, 1, 1, 0); #2;
    chk("t3_stall", stall_f, 0);
    tick();
    idle(); #2;
    chk("t3_fwd_a", fa_f, 0);
    chk("t3_fwd_b", fb_f, 0);
    tick();
    // load-use with redirect in the same cycle
    put(1, 0, 0, 1, 0, 7, 1, 1); #2;
    tick();
    put(1, 7, 7, 1, 1, 8, 1, 0);
    redirect = 1'b1; #2;
    chk("t4_stall", stall_f, 0);
    chk("t4_flush", flush_f, 1);
    chk("t4_bubble", bubble_f, 1);
    tick();
    redirect = 1'b0;
    idle(); #2;
    chk("t4_slot0", sv_f[0], 0);
    chk("t4_slot1", sv_f[1], 1);
    chk("t4_flush_cnt", fc_f, 1);
    chk("t4_fwd_a", fa_f, 0);
    chk("t4_stall_cnt", sc_f, 1);
    tick();
    // reset asserted during a load-use stall
    put(1, 0, 0, 1, 0, 5, 1, 1); #2;
    tick();
    put(1, 5, 5, 1, 1, 6, 1, 0); #2;
    chk("t6_pre_stall", stall_f, 1);
    rst = 1'b1; #1;
    chk("t6_stall", stall_f, 0);
    chk("t6_bubble", bubble_f, 0);
    chk("t6_slots", sv_f, 0);
    chk("t6_stall_cnt", sc_f, 0);
    chk("t6_flush_cnt", fc_f, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("t6_post_stall", stall_f, 0);
    tick();
    idle(); #2;
    chk("t6_post_slot0", sv_f[0], 1);
    repeat (3) tick();
    // no-forwarding build: add r3 ; use r3 stalls until the producer retires
    put(1, 1, 2, 1, 1, 3, 1, 0); #2;
    chk("t5_add_stall", stall_n, 0);
    tick();
    put(1, 3, 1, 1, 1, 4, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("t5_stall%0d", i), stall_n, 1);
      tick();
    end
    #2;
    chk("t5_release", stall_n, 0);
    tick();
    idle(); #2;
    chk("t5_fwd_a", fa_n, 0);
    chk("t5_fwd_b", fb_n, 0);
    chk("t5_stall_cnt", sc_n, 3);
    chk("t5_slot0", sv_n[0], 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
